// File: rtl/npu_pkg.sv
// npu_pkg: shared tags, packer state encoding and lane mask helper for the NPU stream path.
package npu_pkg;
    localparam logic TAG_INPUT  = 1'b0;
    localparam logic TAG_WEIGHT = 1'b1;
    localparam int   MAX_LANES  = 32;

    typedef enum logic {PK_EMPTY, PK_FILL} pk_state_e;

    function automatic logic [MAX_LANES-1:0] lane_sel(input int unsigned idx);
        return MAX_LANES'(1) << idx;
    endfunction
endpackage

// File: rtl/npu_axis_out_reg.sv
// npu_axis_out_reg: single-entry valid/ready holding register driving a stream master.
module npu_axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // load_i is only raised while ready_o is high, so a held beat is never overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/npu_axis_packer.sv
// npu_axis_packer: packs a narrow element stream into ARRAY_SIZE-lane AXI4-Stream beats
// with tkeep/tlast/tuser, plus beat/frame counters and a tag-switch error pulse.
module npu_axis_packer
    import npu_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_last,
    input  logic                           in_user,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] m_tdata,
    output logic [ARRAY_SIZE-1:0]          m_tkeep,
    output logic                           m_tlast,
    output logic                           m_tuser,
    output logic [CNT_WIDTH-1:0]           beat_count,
    output logic [CNT_WIDTH-1:0]           frame_count,
    output logic                           err_tag_switch
);
    localparam int IW = $clog2(ARRAY_SIZE);
    localparam int LW = ARRAY_SIZE * DATA_WIDTH;
    localparam int PW = LW + ARRAY_SIZE + 2;

    pk_state_e           state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       lanes_q, lanes_d, lanes_new;
    logic [ARRAY_SIZE-1:0] keep_q, keep_d, keep_new;
    logic                tag_q, tag_d, cur_tag;
    logic                err_q;
    logic [CNT_WIDTH-1:0] beat_q, frame_q;
    logic                accept, complete;

    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || idx_q == IW'(ARRAY_SIZE - 1));
    assign cur_tag  = (state_q == PK_EMPTY) ? in_user : tag_q;
    assign keep_new = keep_q | ARRAY_SIZE'(lane_sel(32'(idx_q)));

    always_comb begin
        lanes_new = lanes_q;
        lanes_new[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    always_comb begin
        state_d = complete ? PK_EMPTY : accept ? PK_FILL : state_q;
        idx_d   = complete ? '0 : accept ? idx_q + 1'b1 : idx_q;
        lanes_d = complete ? '0 : accept ? lanes_new : lanes_q;
        keep_d  = complete ? '0 : accept ? keep_new : keep_q;
        tag_d   = complete ? TAG_INPUT : accept ? cur_tag : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PK_EMPTY;
            idx_q   <= '0;
            lanes_q <= '0;
            keep_q  <= '0;
            tag_q   <= TAG_INPUT;
            err_q   <= 1'b0;
            beat_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            keep_q  <= keep_d;
            tag_q   <= tag_d;
            err_q   <= accept && state_q == PK_FILL && in_user != tag_q;
            if (m_tvalid && m_tready) begin
                beat_q  <= beat_q + 1'b1;
                frame_q <= frame_q + CNT_WIDTH'(m_tlast);
            end
        end
    end

    npu_axis_out_reg #(.W(PW)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (complete),
        .data_i  ({lanes_new, keep_new, in_last, cur_tag}),
        .ready_i (m_tready),
        .ready_o (in_ready),
        .valid_o (m_tvalid),
        .data_o  ({m_tdata, m_tkeep, m_tlast, m_tuser})
    );

    assign beat_count     = beat_q;
    assign frame_count    = frame_q;
    assign err_tag_switch = err_q;
endmodule

// File: tb/tb_npu_axis_packer.sv
// tb_npu_axis_packer: directed plus random stimulus; a frame-level reference model
// queues expected beats and a monitor checks each output handshake against them.
module tb_npu_axis_packer;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [N*DW-1:0] d;
        logic [N-1:0]    k;
        logic            l;
        logic            u;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_last, in_user;
    logic [DW-1:0]   in_data;
    logic            m_tvalid, m_tready, m_tlast, m_tuser;
    logic [N*DW-1:0] m_tdata;
    logic [N-1:0]    m_tkeep;
    logic [15:0]     beat_count, frame_count;
    logic            err_tag_switch;

    int n_chk = 0;
    int n_fail = 0;
    int stall_n = 0;
    int rdy_mode = 0;

    beat_t       exp_q[$];
    logic [7:0]  cur_d[$];
    logic        cur_u;

    npu_axis_packer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_user        (in_user),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .beat_count     (beat_count),
        .frame_count    (frame_count),
        .err_tag_switch (err_tag_switch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted elements per beat, emits a beat at N elements or on last
    logic err_exp = 1'b0;
    logic beat_due = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            cur_d.delete();
            exp_q.delete();
            err_exp = 1'b0;
            beat_due = 1'b0;
        end else begin
            chk("err_tag_switch", err_tag_switch, err_exp);
            if (beat_due) chk("beat_latency_valid", m_tvalid, 1'b1);
            err_exp = 1'b0;
            beat_due = 1'b0;
            if (in_valid && in_ready) begin
                if (cur_d.size() == 0) cur_u = in_user;
                else if (in_user != cur_u) err_exp = 1'b1;
                cur_d.push_back(in_data);
                if (cur_d.size() == N || in_last) begin
                    b = '0;
                    for (int k = 0; k < cur_d.size(); k++) begin
                        b.d[k*DW +: DW] = cur_d[k];
                        b.k[k] = 1'b1;
                    end
                    b.l = in_last;
                    b.u = cur_u;
                    exp_q.push_back(b);
                    cur_d.delete();
                    beat_due = 1'b1;
                end
            end
        end
    end

    // Monitor: handshake scoreboard, AXI stability, in_ready rule, counters
    logic [15:0] exp_beats = 0, exp_frames = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    beat_t       prev_b;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_beats = 0;
            exp_frames = 0;
            prev_v = 1'b0;
        end else begin
            chk("in_ready", in_ready, !m_tvalid || m_tready);
            chk("beat_count", beat_count, exp_beats);
            chk("frame_count", frame_count, exp_frames);
            if (prev_v && !prev_r)
                chk("stable_while_stalled", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, {1'b1, prev_b});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_tdata, e.d);
                    chk("tkeep", m_tkeep, e.k);
                    chk("tlast", m_tlast, e.l);
                    chk("tuser", m_tuser, e.u);
                end
                exp_beats++;
                if (m_tlast) exp_frames++;
            end
            prev_v = m_tvalid;
            prev_r = m_tready;
            prev_b = {m_tdata, m_tkeep, m_tlast, m_tuser};
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_n > 0) begin
                m_tready = 1'b0;
                stall_n--;
            end else begin
                m_tready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic u);
        int g = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        in_user = u;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        chk("send_accepted", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || m_tvalid) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_done", {exp_q.size() != 0, m_tvalid}, 0);
    endtask

    initial begin
        logic ru;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_user = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast_tuser", {m_tlast, m_tuser}, 0);
        chk("rst_counts", {beat_count, frame_count}, 0);
        chk("rst_err", err_tag_switch, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1); send(8'h44, 1, 1);
        drain();
        chk("t1_frame_count", frame_count, 1);

        for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 0);
        drain();
        chk("t2_beat_count", beat_count, 3);

        stall_n = 6;
        for (int i = 1; i <= 12; i++) send(8'(i), 0, 0);
        drain();
        chk("t3_beat_count", beat_count, 6);

        send(8'hA0, 0, 0); send(8'hA1, 0, 1); send(8'hA2, 0, 0); send(8'hA3, 1, 0);
        drain();

        send(8'h55, 0, 1); send(8'h66, 0, 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_counts_after_rst", {beat_count, frame_count}, 0);
        chk("t5_tvalid_after_rst", m_tvalid, 0);
        @(posedge clk);
        #1;
        send(8'h77, 1, 1);
        drain();
        chk("t5_beat_count", beat_count, 1);

        send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 0, 0);
        send(8'h9C, 1, 0);
        drain();

        rdy_mode = 1;
        ru = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ru = ~ru;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), $urandom_range(0, 5) == 0, ru);
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
